xgmii_tx_sched: RTL

Two-source XGMII transmit scheduler for the 156.25 MHz side of the GMII/XGMII bridge. It round-robin arbitrates whole frames from two 64-bit word streams and frames them onto XGMII. Framing covers the start/preamble word, data, lane-masked terminate, and a minimum idle gap. It also counts underruns.

---
 rtl/gmii2xgmii_pkg.sv | 24 ++
 rtl/xgmii_tx_sched_if.sv | 39 +++
 rtl/xgmii_term_encoder.sv | 32 +++
 rtl/xgmii_tx_sched.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/gmii2xgmii_pkg.sv
// XGMII character set, canned control words and scheduler state encoding shared by both
// directions of the GMII/XGMII bridge.
package gmii2xgmii_pkg;

    localparam logic [7:0] CharIdle     = 8'h07;
    localparam logic [7:0] CharStart    = 8'hfb;
    localparam logic [7:0] CharTerm     = 8'hfd;
    localparam logic [7:0] CharError    = 8'hfe;
    localparam logic [7:0] CharPreamble = 8'h55;
    localparam logic [7:0] CharSfd      = 8'hd5;

    typedef logic [2:0] state_t;

    localparam logic [63:0] IdleWord  = {8{CharIdle}};
    localparam logic [63:0] ErrorWord = {8{CharError}};
    localparam logic [63:0] StartWord = {CharSfd, {6{CharPreamble}}, CharStart};
    localparam logic [63:0] TermWord  = {{7{CharIdle}}, CharTerm};

    // A final-word byte count of zero means the whole word is valid.
    function automatic logic [3:0] nbytes_count(input logic [2:0] nbytes);
        return (nbytes == 3'd0) ? 4'd8 : {1'b0, nbytes};
    endfunction

endpackage

// File: rtl/xgmii_tx_sched_if.sv
// Source streams, enable, XGMII bus and status of the two-source XGMII transmit scheduler.
interface xgmii_tx_sched_if;

    logic        tx_enable;

    logic        src0_valid;
    logic [63:0] src0_data;
    logic        src0_last;
    logic [2:0]  src0_nbytes;
    logic        src0_ready;

    logic        src1_valid;
    logic [63:0] src1_data;
    logic        src1_last;
    logic [2:0]  src1_nbytes;
    logic        src1_ready;

    logic [63:0] xgmii_txd;
    logic [7:0]  xgmii_txc;
    logic        busy;
    logic [15:0] underrun_cnt;

    modport master (
        output tx_enable,
        output src0_valid, src0_data, src0_last, src0_nbytes,
        output src1_valid, src1_data, src1_last, src1_nbytes,
        input  src0_ready, src1_ready,
        input  xgmii_txd, xgmii_txc, busy, underrun_cnt
    );

    modport slave (
        input  tx_enable,
        input  src0_valid, src0_data, src0_last, src0_nbytes,
        input  src1_valid, src1_data, src1_last, src1_nbytes,
        output src0_ready, src1_ready,
        output xgmii_txd, xgmii_txc, busy, underrun_cnt
    );

endinterface

// File: rtl/xgmii_term_encoder.sv
// Builds the XGMII word that carries the final data bytes of a frame: data lanes, then the
// terminate character, then idles. A full final word passes through as plain data.
module xgmii_term_encoder
    import gmii2xgmii_pkg::*;
(
    input  logic [63:0] data,
    input  logic [2:0]  nbytes,
    output logic [63:0] txd,
    output logic [7:0]  txc
);

    logic [3:0] n;

    always_comb begin
        n   = nbytes_count(nbytes);
        txd = IdleWord;
        txc = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (4'(i) < n) begin
                txd[8*i +: 8] = data[8*i +: 8];
                txc[i]        = 1'b0;
            end else if (4'(i) == n) begin
                txd[8*i +: 8] = CharTerm;
                txc[i]        = 1'b1;
            end else begin
                txd[8*i +: 8] = CharIdle;
                txc[i]        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/xgmii_tx_sched.sv
// Round-robin frame scheduler for two 64-bit word sources onto XGMII: start word, data,
// lane-masked terminate and a fixed idle gap, with a saturating underrun counter.
module xgmii_tx_sched
    import gmii2xgmii_pkg::*;
#(
    parameter int unsigned IPG_WORDS = 2
) (
    input logic             sys_156,
    input logic             sys_rst,
    xgmii_tx_sched_if.slave bus
);

    localparam state_t StIdle = 3'd0;
    localparam state_t StPre  = 3'd1;
    localparam state_t StData = 3'd2;
    localparam state_t StTerm = 3'd3;
    localparam state_t StIpg  = 3'd4;

    localparam logic [3:0] IpgLoad = 4'(IPG_WORDS);

    state_t      state_q, state_d;
    // Doubles as the last-granted pointer; the reset value favours src0 on the first tie.
    logic        gnt_q, gnt_d;
    logic [3:0]  ipg_q, ipg_d;
    logic [63:0] txd_q, txd_d;
    logic [7:0]  txc_q, txc_d;
    logic        busy_q;
    logic [15:0] urun_q, urun_d;

    logic        sel_valid;
    logic        sel_last;
    logic [63:0] sel_data;
    logic [2:0]  sel_nbytes;
    logic [63:0] enc_txd;
    logic [7:0]  enc_txc;

    assign sel_valid  = gnt_q ? bus.src1_valid  : bus.src0_valid;
    assign sel_last   = gnt_q ? bus.src1_last   : bus.src0_last;
    assign sel_data   = gnt_q ? bus.src1_data   : bus.src0_data;
    assign sel_nbytes = gnt_q ? bus.src1_nbytes : bus.src0_nbytes;

    xgmii_term_encoder u_term_enc (
        .data   (sel_data),
        .nbytes (sel_nbytes),
        .txd    (enc_txd),
        .txc    (enc_txc)
    );

    // Pure state decode, so there is no valid-to-ready path.
    assign bus.src0_ready = (state_q == StData) && !gnt_q;
    assign bus.src1_ready = (state_q == StData) &&  gnt_q;

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        ipg_d   = ipg_q;
        txd_d   = IdleWord;
        txc_d   = 8'hff;
        urun_d  = urun_q;

        case (state_q)
            StIdle: begin
                if (bus.tx_enable && (bus.src0_valid || bus.src1_valid)) begin
                    gnt_d   = (bus.src0_valid && bus.src1_valid) ? !gnt_q : bus.src1_valid;
                    state_d = StPre;
                end
            end
            StPre: begin
                txd_d   = StartWord;
                txc_d   = 8'h01;
                state_d = StData;
            end
            StData: begin
                if (!sel_valid) begin
                    txd_d = ErrorWord;
                    txc_d = 8'hff;
                    if (urun_q != 16'hffff) begin
                        urun_d = urun_q + 16'd1;
                    end
                end else if (!sel_last) begin
                    txd_d = sel_data;
                    txc_d = 8'h00;
                end else begin
                    txd_d = enc_txd;
                    txc_d = enc_txc;
                    // A full final word has no room for the terminate character.
                    if (sel_nbytes == 3'd0) begin
                        state_d = StTerm;
                    end else begin
                        state_d = StIpg;
                        ipg_d   = IpgLoad;
                    end
                end
            end
            StTerm: begin
                txd_d   = TermWord;
                txc_d   = 8'hff;
                state_d = StIpg;
                ipg_d   = IpgLoad;
            end
            StIpg: begin
                if (ipg_q <= 4'd1) begin
                    state_d = StIdle;
                    ipg_d   = 4'd0;
                end else begin
                    ipg_d = ipg_q - 4'd1;
                end
            end
            default: begin
                state_d = StIdle;
                ipg_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge sys_156 or posedge sys_rst) begin
        if (sys_rst) begin
            state_q <= StIdle;
            gnt_q   <= 1'b1;
            ipg_q   <= 4'd0;
            txd_q   <= IdleWord;
            txc_q   <= 8'hff;
            busy_q  <= 1'b0;
            urun_q  <= 16'd0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ipg_q   <= ipg_d;
            txd_q   <= txd_d;
            txc_q   <= txc_d;
            busy_q  <= (state_d != StIdle);
            urun_q  <= urun_d;
        end
    end

    assign bus.xgmii_txd    = txd_q;
    assign bus.xgmii_txc    = txc_q;
    assign bus.busy         = busy_q;
    assign bus.underrun_cnt = urun_q;

endmodule
